// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier
//   Iterative WIDTH x WIDTH multiplier. Each clock does one partial-product
//   add-and-shift step, so a 2*WIDTH product takes WIDTH cycles.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. in_ready is high only in IDLE, and out_valid is high only in
//   DONE. in_valid is ignored in every other state. product is held stable
//   while out_valid=1 and out_ready=0.
//
//   Optional feature: define SEQ_MUL_SIGNED_EN for two's-complement operands.
//   This uses radix-2 Booth recoding and an arithmetic shift. The default
//   build (macro undefined) is an unsigned shift-add multiplier with no
//   Booth logic.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nx;

    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_nx;
    logic [CW-1:0]        count;
    logic                 last_step;

    // (WIDTH+1)-bit ripple adder operands; the top bit keeps the carry (or sign)
    logic [WIDTH:0]       add_x;
    logic [WIDTH:0]       add_y;
    logic [WIDTH:0]       add_s;
    logic                 add_cin;
    logic [WIDTH+1:0]     carry;

    assign last_step = (count == CW'(1));

`ifdef SEQ_MUL_SIGNED_EN
    // Booth history bit: the multiplier bit shifted out on the previous step
    logic                 booth_q;
    logic [1:0]           booth_pair;

    assign booth_pair = {acc[0], booth_q};

    // Booth recoding: 01 adds mcand, 10 subtracts it (invert plus carry-in)
    always_comb begin
        add_x   = {acc[2*WIDTH-1], acc[2*WIDTH-1:WIDTH]};
        add_y   = '0;
        add_cin = 1'b0;
        case (booth_pair)
            2'b01: begin
                add_y   = {mcand[WIDTH-1], mcand};
                add_cin = 1'b0;
            end
            2'b10: begin
                add_y   = ~{mcand[WIDTH-1], mcand};
                add_cin = 1'b1;
            end
            default: begin
                add_y   = '0;
                add_cin = 1'b0;
            end
        endcase
    end
`else
    // Unsigned step: add mcand into the high half when the current multiplier bit is 1
    always_comb begin
        add_x   = {1'b0, acc[2*WIDTH-1:WIDTH]};
        add_y   = acc[0] ? {1'b0, mcand} : '0;
        add_cin = 1'b0;
    end
`endif

    // Gate-level full-adder ripple chain
    always_comb begin
        carry    = '0;
        add_s    = '0;
        carry[0] = add_cin;
        for (int i = 0; i <= WIDTH; i++) begin
            add_s[i]     = add_x[i] ^ add_y[i] ^ carry[i];
            carry[i + 1] = (add_x[i] & add_y[i]) | (carry[i] & (add_x[i] ^ add_y[i]));
        end
    end

    // Shift {sum, acc_low} right by one. The sum's top bit becomes the new
    // MSB, which gives a logical shift when unsigned and an arithmetic shift
    // when signed.
    assign acc_nx = {add_s, acc[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath: load operands, iterate, and capture the product on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            booth_q <= 1'b0;
`endif
        end else begin
            if (state == IDLE && in_valid) begin
                mcand   <= a;
                acc     <= {{WIDTH{1'b0}}, b};
                count   <= CW'(WIDTH);
`ifdef SEQ_MUL_SIGNED_EN
                booth_q <= 1'b0;
`endif
            end else if (state == RUN) begin
                acc   <= acc_nx;
                count <= count - CW'(1);
`ifdef SEQ_MUL_SIGNED_EN
                booth_q <= acc[0];
`endif
                if (last_step) begin
                    product <= acc_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier (WIDTH = 16).
// This bench uses a table of {a, b, expected product, backpressure cycles}.
// It also has hand-written sequences for ignored in_valid during RUN and for
// reset in the middle of RUN.
module tb_seq_shift_add_multiplier;

    localparam int W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   product;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
        int             bp;
    } vec_t;

    vec_t vecs[8];

    seq_shift_add_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for in_ready, with a bound on the number of cycles.
    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check({name, " in_ready timeout"}, 64'(in_ready), 64'd1);
    endtask

    // One operation. Checks the latency, the product, stability under
    // backpressure, and the in_ready timing after the handshake.
    // If pulse is set, in_valid is pulsed with 7*7 in the middle of RUN.
    task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic [2*W-1:0] exp, input int bp, input bit pulse);
        int n;
        @(negedge clk);
        wait_ready(name);
        a         = ta;
        b         = tb_;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        check({name, " in_ready low in RUN"}, 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            if (pulse && n == 5) begin
                in_valid = 1'b1;
                a        = W'(7);
                b        = W'(7);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check({name, " latency"}, 64'(n), 64'd16);
        check({name, " product"}, 64'(product), 64'(exp));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check($sformatf("%s bp%0d out_valid", name, i), 64'(out_valid), 64'd1);
            check($sformatf("%s bp%0d product", name, i), 64'(product), 64'(exp));
        end
        out_ready = 1'b1;
        check({name, " in_ready low at handshake"}, 64'(in_ready), 64'd0);
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " in_ready after handshake"}, 64'(in_ready), 64'd1);
        check({name, " out_valid after handshake"}, 64'(out_valid), 64'd0);
        check({name, " product held in IDLE"}, 64'(product), 64'(exp));
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

`ifdef SEQ_MUL_SIGNED_EN
        vecs[0] = '{16'hFFFD, 16'd5,    32'hFFFFFFF1, 0};
        vecs[1] = '{16'h8000, 16'h8000, 32'h40000000, 0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 32'h00000001, 5};
        vecs[3] = '{16'h7FFF, 16'hFFFF, 32'hFFFF8001, 0};
        vecs[4] = '{16'd3,    16'd4,    32'd12,       2};
        vecs[5] = '{16'd0,    16'hFFFB, 32'd0,        0};
        vecs[6] = '{16'h8000, 16'd1,    32'hFFFF8000, 0};
        vecs[7] = '{16'h8000, 16'h7FFF, 32'hC0008000, 0};
`else
        vecs[0] = '{16'd90,   16'd33,   32'h00000B9A, 0};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0};
        vecs[2] = '{16'd0,    16'h1234, 32'd0,        5};
        vecs[3] = '{16'h1234, 16'd0,    32'd0,        0};
        vecs[4] = '{16'd1,    16'hFFFF, 32'h0000FFFF, 1};
        vecs[5] = '{16'h8000, 16'd2,    32'h00010000, 0};
        vecs[6] = '{16'h00FF, 16'h0101, 32'h0000FFFF, 0};
        vecs[7] = '{16'd1000, 16'd1000, 32'd1000000,  3};
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset product", 64'(product), 64'd0);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].bp, 1'b0);
        end

        // in_valid pulsed during RUN is ignored
        do_op("ignore_pulse", 16'd901, 16'd300, 32'h00041FDC, 0, 1'b1);

        // Reset in the middle of RUN discards the partial result
        @(negedge clk);
        wait_ready("midreset");
        a        = 16'h1234;
        b        = 16'h5678;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("midreset busy", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("midreset in_ready", 64'(in_ready), 64'd1);
        check("midreset out_valid", 64'(out_valid), 64'd0);
        check("midreset product", 64'(product), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after_reset", 16'd5, 16'd6, 32'd30, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
